// File: rtl/ni_flit_injector.sv
// ni_flit_injector: turns core-side packet requests into head/body/tail flits
// for the router local input port. Allocates a drained VC per packet and
// paces flits with per-VC credit counters fed by the router's credit return.
module ni_flit_injector #(
    parameter int V    = 4,
    parameter int B    = 4,
    parameter int NX   = 4,
    parameter int NY   = 4,
    parameter int C    = 2,
    parameter int Fpay = 32,
    parameter int Lw   = 5,
    localparam int Xw  = (NX > 1) ? $clog2(NX) : 1,
    localparam int Yw  = (NY > 1) ? $clog2(NY) : 1,
    localparam int Cw  = (C > 1) ? $clog2(C) : 1,
    localparam int Fw  = 2 + V + Fpay,
    localparam int CRw = $clog2(B + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Xw-1:0]   current_x,
    input  logic [Yw-1:0]   current_y,
    input  logic            pkt_req,
    input  logic [Xw-1:0]   pkt_dest_x,
    input  logic [Yw-1:0]   pkt_dest_y,
    input  logic [Cw-1:0]   pkt_class,
    input  logic [Lw-1:0]   pkt_len,
    output logic            pkt_ack,
    input  logic [Fpay-1:0] pld_data,
    output logic            pld_rd,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_we,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output logic            credit_err
);

    // Width of the routing header packed into the low payload bits of a head flit
    localparam int HW = 2 * Xw + 2 * Yw + Cw;
    localparam logic [CRw-1:0] B_CR  = CRw'(B);
    localparam logic [CRw:0]   B_EXT = (CRw + 1)'(B);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VCSEL = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [Xw-1:0]   dest_x_q, dest_x_d;
    logic [Yw-1:0]   dest_y_q, dest_y_d;
    logic [Cw-1:0]   class_q, class_d;
    logic [Lw-1:0]   len_q, len_d;
    logic [Lw-1:0]   idx_q, idx_d;
    logic [V-1:0]    vc_sel_q, vc_sel_d;
    logic            ack_q, ack_d;
    logic            credit_err_q, credit_err_d;
    logic [Fw-1:0]   flit_hold_q, flit_hold_d;

    logic [V-1:0]    drained;
    logic [V-1:0]    has_credit;
    logic [V-1:0]    overflow;
    logic [V-1:0]    first_free;
    logic            any_free;
    logic            send;
    logic            is_head;
    logic            is_tail;
    logic [Fpay-1:0] head_payload;
    logic [Fw-1:0]   flit_body;

    // A VC is eligible for a new packet only once the router has returned every credit
    assign first_free = drained & (~drained + V'(1));
    assign any_free   = |drained;

    // A flit goes out only when the selected VC still has buffer space downstream
    assign send    = (state_q == S_SEND) && (|(vc_sel_q & has_credit));
    assign is_head = (idx_q == '0);
    assign is_tail = (idx_q == (len_q - Lw'(1)));

    // Per-VC credit counters: spend on send, refill on return, saturate at B
    generate
        for (genvar gi = 0; gi < V; gi++) begin : g_vc
            logic [CRw-1:0] cnt_q, cnt_d;
            logic [CRw:0]   sum;

            // Net credit change this cycle; a return into a full counter is clipped
            always_comb begin
                sum = {1'b0, cnt_q}
                    + {{CRw{1'b0}}, credit_in[gi]}
                    - {{CRw{1'b0}}, (send & vc_sel_q[gi])};
                if (sum > B_EXT) begin
                    cnt_d = B_CR;
                end else begin
                    cnt_d = sum[CRw-1:0];
                end
            end

            // Counter register, full on reset
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= B_CR;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign overflow[gi]   = (sum > B_EXT);
            assign drained[gi]    = (cnt_q == B_CR);
            assign has_credit[gi] = (cnt_q != '0);
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept, wait for a drained VC, stream flits until the tail
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pkt_req)         state_d = S_VCSEL;
            S_VCSEL: if (any_free)        state_d = S_SEND;
            S_SEND:  if (send && is_tail) state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Packet context: latch the request, pick the VC, advance the flit index
    always_comb begin
        dest_x_d     = dest_x_q;
        dest_y_d     = dest_y_q;
        class_d      = class_q;
        len_d        = len_q;
        idx_d        = idx_q;
        vc_sel_d     = vc_sel_q;
        ack_d        = 1'b0;
        credit_err_d = credit_err_q | (|overflow);
        if ((state_q == S_IDLE) && pkt_req) begin
            dest_x_d = pkt_dest_x;
            dest_y_d = pkt_dest_y;
            class_d  = pkt_class;
            len_d    = (pkt_len == '0) ? Lw'(1) : pkt_len;
            ack_d    = 1'b1;
        end
        if ((state_q == S_VCSEL) && any_free) begin
            vc_sel_d = first_free;
            idx_d    = '0;
        end
        if (send) begin
            idx_d = idx_q + Lw'(1);
        end
    end

    // Packet context registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_x_q     <= '0;
            dest_y_q     <= '0;
            class_q      <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            vc_sel_q     <= '0;
            ack_q        <= 1'b0;
            credit_err_q <= 1'b0;
            flit_hold_q  <= '0;
        end else begin
            dest_x_q     <= dest_x_d;
            dest_y_q     <= dest_y_d;
            class_q      <= class_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            vc_sel_q     <= vc_sel_d;
            ack_q        <= ack_d;
            credit_err_q <= credit_err_d;
            flit_hold_q  <= flit_hold_d;
        end
    end

    // Output decode: compose the flit; while stalled, keep presenting the last one sent
    always_comb begin
        head_payload           = '0;
        head_payload[HW-1:0]   = {dest_x_q, dest_y_q, current_x, current_y, class_q};
        flit_body              = '0;
        flit_body[Fw-1]        = is_head;
        flit_body[Fw-2]        = is_tail;
        flit_body[Fpay +: V]   = vc_sel_q;
        flit_body[Fpay-1:0]    = is_head ? head_payload : pld_data;
        flit_out_we            = send;
        pld_rd                 = send && !is_head;
        flit_out               = send ? flit_body : flit_hold_q;
        flit_hold_d            = flit_out;
        pkt_ack                = ack_q;
        busy                   = (state_q != S_IDLE);
        credit_err             = credit_err_q;
    end

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: table-driven packets, hand-written credit/VC/reset
// sequences, then random traffic checked against a credit/flit scoreboard.
module tb_ni_flit_injector;

    localparam int V = 4;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  current_x, current_y;
    logic        pkt_req;
    logic [1:0]  pkt_dest_x, pkt_dest_y;
    logic        pkt_class;
    logic [4:0]  pkt_len;
    logic        pkt_ack;
    logic [31:0] pld_data;
    logic        pld_rd;
    logic [37:0] flit_out;
    logic        flit_out_we;
    logic [3:0]  credit_in;
    logic        busy;
    logic        credit_err;

    always #5 clk = ~clk;

    ni_flit_injector dut (
        .clk        (clk),
        .reset      (reset),
        .current_x  (current_x),
        .current_y  (current_y),
        .pkt_req    (pkt_req),
        .pkt_dest_x (pkt_dest_x),
        .pkt_dest_y (pkt_dest_y),
        .pkt_class  (pkt_class),
        .pkt_len    (pkt_len),
        .pkt_ack    (pkt_ack),
        .pld_data   (pld_data),
        .pld_rd     (pld_rd),
        .flit_out   (flit_out),
        .flit_out_we(flit_out_we),
        .credit_in  (credit_in),
        .busy       (busy),
        .credit_err (credit_err)
    );

    int errors = 0;
    int checks = 0;
    int occ[V];

    typedef struct {
        logic [1:0] dx;
        logic [1:0] dy;
        logic       cls;
        logic [4:0] len;
        logic       flush;
        logic [3:0] exp_vc;
        logic [8:0] exp_head;
        int         exp_nfl;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pld_data = $urandom();
        #1;
    endtask

    function automatic int vc_idx(input logic [3:0] oh);
        for (int i = 0; i < V; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        pkt_req   = 1'b0;
        credit_in = '0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        for (int v = 0; v < V; v++) occ[v] = 0;
        step();
    endtask

    // Return every outstanding credit, one per VC per cycle
    task automatic flush();
        int guard = 0;
        while ((occ[0] + occ[1] + occ[2] + occ[3]) > 0 && guard < 20) begin
            for (int v = 0; v < V; v++) begin
                if (occ[v] > 0) begin
                    credit_in[v] = 1'b1;
                    occ[v]--;
                end
            end
            step();
            credit_in = '0;
            guard++;
        end
        step();
    endtask

    // Issue one request with no stall expected and check the whole flit train
    task automatic do_packet(input string tag, input logic [1:0] dx, input logic [1:0] dy,
                             input logic cls, input logic [4:0] len, input logic [3:0] exp_vc,
                             input logic [8:0] exp_head, input int exp_nfl);
        int nfl = 0;
        int nrd = 0;
        int waited = 0;
        int head_wait = -1;
        logic seen_tail = 1'b0;
        pkt_dest_x = dx;
        pkt_dest_y = dy;
        pkt_class  = cls;
        pkt_len    = len;
        pkt_req    = 1'b1;
        step();
        chk({tag, "_ack"}, pkt_ack, 1);
        chk({tag, "_busy"}, busy, 1);
        pkt_req = 1'b0;
        step();
        chk({tag, "_ack_pulse"}, pkt_ack, 0);
        while (!seen_tail && waited < 40) begin
            if (flit_out_we) begin
                if (nfl == 0) begin
                    head_wait = waited;
                    chk({tag, "_head_bit"}, flit_out[37], 1);
                    chk({tag, "_head_pl"}, flit_out[31:0], {23'd0, exp_head});
                    chk({tag, "_head_rd"}, pld_rd, 0);
                end else begin
                    chk({tag, "_body_head"}, flit_out[37], 0);
                    chk({tag, "_body_pl"}, flit_out[31:0], pld_data);
                    chk({tag, "_body_rd"}, pld_rd, 1);
                end
                chk({tag, "_vc"}, flit_out[35:32], exp_vc);
                chk({tag, "_tail"}, flit_out[36], (nfl == exp_nfl - 1));
                nrd += int'(pld_rd);
                seen_tail = flit_out[36];
                occ[vc_idx(flit_out[35:32])]++;
                nfl++;
            end
            if (!seen_tail) begin
                step();
                waited++;
            end
        end
        chk({tag, "_head_latency"}, head_wait, 0);
        chk({tag, "_nflits"}, nfl, exp_nfl);
        chk({tag, "_nrd"}, nrd, exp_nfl - 1);
        step();
        chk({tag, "_busy_end"}, busy, 0);
        $display("pkt %s: dest=(%0d,%0d) len=%0d flits=%0d", tag, dx, dy, len, nfl);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] last_flit;
        int mcnt[V];
        int prev[V];
        int in_pkt, req_on, fcnt, exp_len, cur_vc, npk, ev, vi;
        logic [8:0] exp_head;

        pld_data   = '0;
        pkt_dest_x = '0;
        pkt_dest_y = '0;
        pkt_class  = 1'b0;
        pkt_len    = '0;
        current_x  = 2'd1;
        current_y  = 2'd2;

        // Reset values while reset is held
        reset     = 1'b0;
        pkt_req   = 1'b0;
        credit_in = '0;
        @(posedge clk);
        #2;
        chk("rst_ack", pkt_ack, 0);
        chk("rst_rd", pld_rd, 0);
        chk("rst_we", flit_out_we, 0);
        chk("rst_flit", flit_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", credit_err, 0);
        do_reset();

        // Table: consecutive packets, some leaving credits outstanding
        vecs[0] = '{2'd3, 2'd0, 1'b1, 5'd3, 1'b0, 4'b0001, 9'h18D, 3};
        vecs[1] = '{2'd0, 2'd3, 1'b0, 5'd1, 1'b0, 4'b0010, 9'h06C, 1};
        vecs[2] = '{2'd2, 2'd1, 1'b1, 5'd0, 1'b1, 4'b0100, 9'h12D, 1};
        vecs[3] = '{2'd1, 2'd1, 1'b0, 5'd4, 1'b1, 4'b0001, 9'h0AC, 4};
        vecs[4] = '{2'd3, 2'd3, 1'b1, 5'd2, 1'b1, 4'b0001, 9'h1ED, 2};
        for (int i = 0; i < 5; i++) begin
            do_packet($sformatf("tbl%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].cls, vecs[i].len,
                      vecs[i].exp_vc, vecs[i].exp_head, vecs[i].exp_nfl);
            if (vecs[i].flush) flush();
        end

        // Credit stall on VC0: 4 flits, stall, one flit per credit, coincident return
        do_reset();
        pkt_dest_x = 2'd2; pkt_dest_y = 2'd2; pkt_class = 1'b0; pkt_len = 5'd7;
        pkt_req = 1'b1;
        step();
        chk("stall_ack", pkt_ack, 1);
        pkt_req = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            chk("stall_burst_we", flit_out_we, 1);
            last_flit = flit_out;
            step();
        end
        for (int c = 0; c < 3; c++) begin
            chk("stall_we", flit_out_we, 0);
            chk("stall_rd", pld_rd, 0);
            chk("stall_hold", flit_out, last_flit);
            step();
        end
        credit_in[0] = 1'b1;
        step();
        credit_in = '0;
        chk("pulse1_we", flit_out_we, 1);
        chk("pulse1_tail", flit_out[36], 0);
        step();
        chk("pulse1_single", flit_out_we, 0);
        credit_in[0] = 1'b1;
        step();
        chk("pulse2_we", flit_out_we, 1);
        chk("pulse2_tail", flit_out[36], 0);
        step();
        credit_in = '0;
        chk("coincident_we", flit_out_we, 1);
        chk("coincident_tail", flit_out[36], 1);
        step();
        chk("stall_busy_end", busy, 0);
        occ[0] = 4;
        $display("seq stall: done");

        // VC allocation: fill VC1..VC3, then wait in VCSEL until one drains
        do_packet("vc1", 2'd0, 2'd0, 1'b0, 5'd1, 4'b0010, 9'h00C, 1);
        do_packet("vc2", 2'd0, 2'd0, 1'b0, 5'd1, 4'b0100, 9'h00C, 1);
        do_packet("vc3", 2'd0, 2'd0, 1'b0, 5'd1, 4'b1000, 9'h00C, 1);
        pkt_len = 5'd1;
        pkt_req = 1'b1;
        step();
        chk("wait_ack", pkt_ack, 1);
        pkt_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("wait_we", flit_out_we, 0);
            chk("wait_no_reack", pkt_ack, 0);
            chk("wait_busy", busy, 1);
        end
        credit_in[2] = 1'b1;
        step();
        credit_in = '0;
        chk("wait_we_last", flit_out_we, 0);
        step();
        chk("wait_head_we", flit_out_we, 1);
        chk("wait_head_vc", flit_out[35:32], 4'b0100);
        chk("wait_head_tail", flit_out[36], 1);
        step();
        $display("seq vcsel-wait: done");

        // Credit returned into a full counter sets a sticky error
        credit_in[3] = 1'b1;
        step();
        credit_in = '0;
        chk("err_clear", credit_err, 0);
        credit_in[3] = 1'b1;
        step();
        credit_in = '0;
        chk("err_set", credit_err, 1);
        repeat (3) begin
            step();
            chk("err_sticky", credit_err, 1);
        end
        $display("seq credit_err: done");

        // Asynchronous reset in the middle of a long packet
        do_reset();
        pkt_dest_x = 2'd1; pkt_dest_y = 2'd3; pkt_class = 1'b1; pkt_len = 5'd8;
        pkt_req = 1'b1;
        step();
        pkt_req = 1'b0;
        repeat (3) step();
        chk("midrst_pre_we", flit_out_we, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_we", flit_out_we, 0);
        chk("midrst_flit", flit_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd", pld_rd, 0);
        chk("midrst_err", credit_err, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int v = 0; v < V; v++) occ[v] = 0;
        step();
        chk("midrst_idle_we", flit_out_we, 0);
        do_packet("postrst", 2'd3, 2'd0, 1'b1, 5'd2, 4'b0001, 9'h18D, 2);
        $display("seq async-reset: done");

        // Random traffic against a scoreboard acting as the router input buffers
        do_reset();
        current_x = 2'($urandom_range(0, 3));
        current_y = 2'($urandom_range(0, 3));
        for (int v = 0; v < V; v++) begin
            mcnt[v] = B;
            prev[v] = B;
        end
        in_pkt = 0; req_on = 0; fcnt = 0; exp_len = 1; cur_vc = 0; npk = 0;
        exp_head = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            pld_data  = $urandom();
            credit_in = '0;
            for (int v = 0; v < V; v++) begin
                if (occ[v] > 0 && $urandom_range(0, 2) == 0) begin
                    credit_in[v] = 1'b1;
                    occ[v]--;
                end
            end
            if (!req_on && cyc < 3600 && $urandom_range(0, 3) == 0) begin
                pkt_dest_x = 2'($urandom_range(0, 3));
                pkt_dest_y = 2'($urandom_range(0, 3));
                pkt_class  = 1'($urandom_range(0, 1));
                pkt_len    = 5'($urandom_range(0, 12));
                pkt_req    = 1'b1;
                req_on     = 1;
            end
            #1;
            if (pkt_ack) begin
                chk("rnd_ack_has_req", req_on, 1);
                chk("rnd_ack_idle", in_pkt, 0);
                exp_len  = (pkt_len == 0) ? 1 : int'(pkt_len);
                exp_head = {pkt_dest_x, pkt_dest_y, current_x, current_y, pkt_class};
                fcnt     = 0;
                in_pkt   = 1;
                req_on   = 0;
                pkt_req  = 1'b0;
            end
            vi = vc_idx(flit_out[35:32]);
            if (flit_out_we) begin
                chk("rnd_vc_onehot", $onehot(flit_out[35:32]), 1);
                chk("rnd_in_pkt", in_pkt, 1);
                chk("rnd_credit_avail", mcnt[vi] > 0, 1);
                if (fcnt == 0) begin
                    ev = -1;
                    for (int v = V - 1; v >= 0; v--) if (prev[v] == B) ev = v;
                    chk("rnd_head_vc", vi, ev);
                    chk("rnd_head_bit", flit_out[37], 1);
                    chk("rnd_head_pl", flit_out[31:0], {23'd0, exp_head});
                    chk("rnd_head_rd", pld_rd, 0);
                    cur_vc = vi;
                end else begin
                    chk("rnd_body_head", flit_out[37], 0);
                    chk("rnd_body_vc", vi, cur_vc);
                    chk("rnd_body_pl", flit_out[31:0], pld_data);
                    chk("rnd_body_rd", pld_rd, 1);
                end
                chk("rnd_tail", flit_out[36], (fcnt == exp_len - 1));
                fcnt++;
                occ[vi]++;
                chk("rnd_buf_overflow", occ[vi] <= B, 1);
                if (flit_out[36]) begin
                    in_pkt = 0;
                    npk++;
                    $display("rnd pkt %0d: vc=%0d len=%0d", npk, vi, fcnt);
                end
            end else begin
                chk("rnd_rd_idle", pld_rd, 0);
            end
            prev = mcnt;
            for (int v = 0; v < V; v++) begin
                mcnt[v] = mcnt[v] + int'(credit_in[v]) - ((flit_out_we && vi == v) ? 1 : 0);
            end
        end
        #2;
        chk("rnd_end_busy", busy, 0);
        chk("rnd_end_in_pkt", in_pkt, 0);
        chk("rnd_end_req", req_on, 0);
        chk("rnd_end_err", credit_err, 0);
        chk("rnd_pkt_count", npk > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
